// File: rtl/pwm_modulator.sv
// Triangle-carrier PWM modulator for one half-bridge leg.
// Double-buffered duty, valley sync pulse, latched hardware fault; no dead time.
module pwm_modulator #(
   parameter int unsigned PH    = 270,
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_fault,
   input  logic             i_fault_clr,
   input  logic [CNT_W-1:0] i_duty,
   input  logic             i_duty_valid,
   output logic [1:0]       o_pwm,
   output logic             o_sync,
   output logic [CNT_W-1:0] o_carrier,
   output logic             o_fault_latched
);

   localparam logic [CNT_W-1:0] PH_C   = CNT_W'(PH);
   localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             dir_down, dir_down_nxt;
   logic [CNT_W-1:0] carrier_nxt;
   logic [CNT_W-1:0] shadow, shadow_nxt;
   logic [CNT_W-1:0] active, active_nxt;
   logic [CNT_W-1:0] active_eff;
   logic [1:0]       pwm_nxt;
   logic             sync_nxt;
   logic             valley;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         dir_down        <= 1'b0;
         o_carrier       <= ZERO_C;
         shadow          <= ZERO_C;
         active          <= ZERO_C;
         o_pwm           <= 2'b00;
         o_sync          <= 1'b0;
         o_fault_latched <= 1'b0;
      end else begin
         state           <= state_nxt;
         dir_down        <= dir_down_nxt;
         o_carrier       <= carrier_nxt;
         shadow          <= shadow_nxt;
         active          <= active_nxt;
         o_pwm           <= pwm_nxt;
         o_sync          <= sync_nxt;
         o_fault_latched <= (state_nxt == FAULT);
      end
   end

   // The valley cycle already compares against the freshly loaded shadow value.
   assign valley     = (state == RUN) && (o_carrier == ZERO_C);
   assign active_eff = valley ? shadow : active;

   always_comb begin
      state_nxt    = state;
      dir_down_nxt = 1'b0;
      carrier_nxt  = ZERO_C;
      shadow_nxt   = shadow;
      active_nxt   = active;
      pwm_nxt      = 2'b00;
      sync_nxt     = 1'b0;

      if (i_fault) begin
         state_nxt = FAULT;
      end else begin
         case (state)
            IDLE:    if (i_en)        state_nxt = RUN;
            RUN:     if (!i_en)       state_nxt = IDLE;
            FAULT:   if (i_fault_clr) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
         endcase
      end

      if (i_duty_valid)
         shadow_nxt = (i_duty > PH_C) ? PH_C : i_duty;

      if (valley)
         active_nxt = shadow;

      // Carrier advances only while staying in RUN; every other path restarts at 0, up.
      if (state == RUN && state_nxt == RUN) begin
         if (!dir_down) begin
            carrier_nxt  = o_carrier + ONE_C;
            dir_down_nxt = (carrier_nxt == PH_C);
         end else begin
            carrier_nxt  = o_carrier - ONE_C;
            dir_down_nxt = (carrier_nxt != ZERO_C);
         end

         if (active_eff == ZERO_C)
            pwm_nxt = 2'b10;
         else if (active_eff == PH_C)
            pwm_nxt = 2'b01;
         else
            pwm_nxt = (o_carrier < active_eff) ? 2'b01 : 2'b10;
      end

      sync_nxt = (state_nxt == RUN) && (carrier_nxt == ZERO_C);
   end

endmodule

// File: tb/tb_pwm_modulator.sv
// Directed self-checking bench for pwm_modulator with PH=8.
module tb_pwm_modulator;

   localparam int unsigned PH    = 8;
   localparam int unsigned CNT_W = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_en = 1'b0;
   logic             i_fault = 1'b0;
   logic             i_fault_clr = 1'b0;
   logic [CNT_W-1:0] i_duty = '0;
   logic             i_duty_valid = 1'b0;
   logic [1:0]       o_pwm;
   logic             o_sync;
   logic [CNT_W-1:0] o_carrier;
   logic             o_fault_latched;

   int n_checks = 0;
   int n_fail   = 0;

   pwm_modulator #(.PH(PH), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_en            (i_en),
      .i_fault         (i_fault),
      .i_fault_clr     (i_fault_clr),
      .i_duty          (i_duty),
      .i_duty_valid    (i_duty_valid),
      .o_pwm           (o_pwm),
      .o_sync          (o_sync),
      .o_carrier       (o_carrier),
      .o_fault_latched (o_fault_latched)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int tri_at(input int j);
      int m;
      m = j % (2 * PH);
      return (m <= int'(PH)) ? m : (2 * int'(PH) - m);
   endfunction

   function automatic logic [1:0] cmp(input int c, input int a);
      if (a == 0)               return 2'b10;
      else if (a == int'(PH))   return 2'b01;
      else                      return (c < a) ? 2'b01 : 2'b10;
   endfunction

   // Steps one full period starting at a valley, checking carrier/sync/pwm against the model.
   task automatic run_period(input string tag, input int act, input int strobe_step,
                             input int d, output int hi, output int syn, output int bad);
      hi = 0; syn = 0; bad = 0;
      for (int j = 1; j <= 2 * int'(PH); j++) begin
         if (j == strobe_step) begin
            i_duty       = CNT_W'(d);
            i_duty_valid = 1'b1;
         end
         step();
         i_duty_valid = 1'b0;
         check({tag, "_car"}, 32'(o_carrier), 32'(tri_at(j)));
         check({tag, "_pwm"}, 32'(o_pwm), 32'(cmp(tri_at(j - 1), act)));
         if (o_pwm == 2'b01) hi++;
         if (o_pwm == 2'b11) bad++;
         if (o_sync) syn++;
      end
   endtask

   int hi, syn, bad;

   initial begin
      // Reset and idle
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("idle_pwm", 32'(o_pwm), 32'd0);
         check("idle_sync", 32'(o_sync), 32'd0);
         check("idle_car", 32'(o_carrier), 32'd0);
         check("idle_flt", 32'(o_fault_latched), 32'd0);
      end

      // Nominal modulation at duty 4
      i_duty = 10'd4; i_duty_valid = 1'b1;
      step();
      i_duty_valid = 1'b0;
      i_en = 1'b1;
      step();
      check("en_car", 32'(o_carrier), 32'd0);
      check("en_sync", 32'(o_sync), 32'd1);
      check("en_pwm", 32'(o_pwm), 32'd0);
      run_period("nom", 4, 0, 0, hi, syn, bad);
      check("nom_hi", 32'(hi), 32'd7);
      check("nom_sync", 32'(syn), 32'd1);
      check("nom_11", 32'(bad), 32'd0);

      // Double buffering: mid-period strobe, then a strobe at the valley
      run_period("db1", 4, 4, 6, hi, syn, bad);
      check("db1_hi", 32'(hi), 32'd7);
      run_period("db2", 6, 0, 0, hi, syn, bad);
      check("db2_hi", 32'(hi), 32'd11);
      run_period("db3", 6, 1, 4, hi, syn, bad);
      check("db3_hi", 32'(hi), 32'd11);
      run_period("db4", 4, 1, 0, hi, syn, bad);
      check("db4_hi", 32'(hi), 32'd7);

      // Limits: 0, PH, and an over-range value clamped to PH
      run_period("lim0", 0, 1, 8, hi, syn, bad);
      check("lim0_hi", 32'(hi), 32'd0);
      run_period("lim8", 8, 1, 4, hi, syn, bad);
      check("lim8_hi", 32'(hi), 32'd16);
      check("lim8_11", 32'(bad), 32'd0);
      run_period("lim4", 4, 1, 200, hi, syn, bad);
      check("lim4_hi", 32'(hi), 32'd7);
      run_period("lim200", 8, 0, 0, hi, syn, bad);
      check("lim200_hi", 32'(hi), 32'd16);
      check("lim200_11", 32'(bad), 32'd0);

      // Fault mid-period, blocked clear, real clear, restart
      for (int i = 0; i < 5; i++) step();
      check("pre_flt_car", 32'(o_carrier), 32'd5);
      i_fault = 1'b1;
      step();
      check("flt_pwm", 32'(o_pwm), 32'd0);
      check("flt_lat", 32'(o_fault_latched), 32'd1);
      check("flt_car", 32'(o_carrier), 32'd0);
      check("flt_sync", 32'(o_sync), 32'd0);
      i_duty = 10'd4; i_duty_valid = 1'b1;
      i_fault_clr = 1'b1;
      step();
      i_duty_valid = 1'b0;
      step();
      check("flt_hold", 32'(o_fault_latched), 32'd1);
      check("flt_hold_pwm", 32'(o_pwm), 32'd0);
      i_en = 1'b0;
      i_fault = 1'b0;
      step();
      check("flt_clr", 32'(o_fault_latched), 32'd0);
      i_fault_clr = 1'b0;
      step();
      check("clr_idle_sync", 32'(o_sync), 32'd0);
      check("clr_idle_car", 32'(o_carrier), 32'd0);
      i_en = 1'b1;
      step();
      check("re_car", 32'(o_carrier), 32'd0);
      check("re_sync", 32'(o_sync), 32'd1);
      run_period("re", 4, 0, 0, hi, syn, bad);
      check("re_hi", 32'(hi), 32'd7);

      // Disable at carrier 5
      for (int i = 0; i < 5; i++) step();
      check("dis_pre", 32'(o_carrier), 32'd5);
      i_en = 1'b0;
      step();
      check("dis_pwm", 32'(o_pwm), 32'd0);
      check("dis_car", 32'(o_carrier), 32'd0);
      check("dis_sync", 32'(o_sync), 32'd0);
      step();
      check("dis_car2", 32'(o_carrier), 32'd0);

      // Async reset between edges
      i_en = 1'b1;
      step(); step(); step(); step();
      check("ar_pre_car", 32'(o_carrier), 32'd3);
      check("ar_pre_pwm", 32'(o_pwm), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_car", 32'(o_carrier), 32'd0);
      check("ar_pwm", 32'(o_pwm), 32'd0);
      check("ar_sync", 32'(o_sync), 32'd0);
      check("ar_flt", 32'(o_fault_latched), 32'd0);
      i_en = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("ar_idle_car", 32'(o_carrier), 32'd0);
      check("ar_idle_sync", 32'(o_sync), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
